uncache_bridge: RTL and testbench

- Single-outstanding bridge between the CPU's uncached data port (SRAM-like req/addr_ok/data_ok) and the AXI bus.
- It sits behind the address translator. Requests whose physical address is flagged no-cache (kseg1) are routed here instead of the D-cache.
- Each CPU request becomes exactly one single-beat AXI read (AR/R) or write (AW/W/B). Completion is signalled back as a one-cycle data_ok pulse.

---
 rtl/uncache_bridge.sv | 175 +++++++++++++++++
 tb/tb_uncache_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uncache_bridge.sv
// Uncached data-port bridge: turns one CPU SRAM-like request into a single-beat
// AXI read (AR/R) or write (AW/W/B) and returns a one-cycle data_ok pulse.
// Only one transaction is ever outstanding; new requests are taken only in IDLE.
module uncache_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // CPU uncached port
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  // AXI read address / data
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] r_data,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address / data / response
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] w_data,
  output logic [3:0]  w_strb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state_q;
  logic        data_ok_q;
  logic [31:0] rdata_q;
  logic [31:0] araddr_q;
  logic [2:0]  arsize_q;
  logic        arvalid_q;
  logic        rready_q;
  logic [31:0] awaddr_q;
  logic [2:0]  awsize_q;
  logic        awvalid_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wvalid_q;
  logic        bready_q;

  // AW and W channels are each finished once their valid has dropped or handshakes now
  logic aw_fin_s;
  logic w_fin_s;
  assign aw_fin_s = ~awvalid_q | awready;
  assign w_fin_s  = ~wvalid_q  | wready;

  // Acceptance is combinational and only possible with nothing outstanding
  assign addr_ok = req & (state_q == IDLE);

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;
  assign arid    = AXI_ID;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awid    = AXI_ID;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign w_data  = wdata_q;
  assign w_strb  = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  // Transaction FSM with all handshake outputs registered; reset abandons any transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'd0;
      araddr_q  <= 32'd0;
      arsize_q  <= 3'd0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= 32'd0;
      awsize_q  <= 3'd0;
      awvalid_q <= 1'b0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      data_ok_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (wr) begin
              awaddr_q  <= addr;
              awsize_q  <= {1'b0, size};
              wdata_q   <= wdata;
              wstrb_q   <= wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_AW;
            end else begin
              araddr_q  <= addr;
              arsize_q  <= {1'b0, size};
              arvalid_q <= 1'b1;
              state_q   <= RD_A;
            end
          end
        end
        RD_A: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_D;
          end
        end
        RD_D: begin
          if (rvalid) begin
            rdata_q   <= r_data;
            rready_q  <= 1'b0;
            data_ok_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        WR_AW: begin
          if (awvalid_q && awready) begin
            awvalid_q <= 1'b0;
          end
          if (wvalid_q && wready) begin
            wvalid_q <= 1'b0;
          end
          if (aw_fin_s && w_fin_s) begin
            bready_q <= 1'b1;
            state_q  <= WR_B;
          end
        end
        WR_B: begin
          if (bvalid) begin
            bready_q  <= 1'b0;
            data_ok_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uncache_bridge.sv
// Directed bench for uncache_bridge: a transaction-level model predicts every
// output each cycle, and hand-computed literals pin the key cycles of each scenario.
module tb_uncache_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, w_data, r_data;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  w_strb;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  uncache_bridge #(.AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .r_data(r_data), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .w_data(w_data), .w_strb(w_strb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level model ----------------
  // One outstanding transfer; each pending flag is an AXI phase still owed.
  logic        m_busy, m_ar, m_r, m_aw, m_w, m_b, m_done;
  logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_arsz, m_awsz;

  // Model advance on each clock using the handshakes visible before the edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_ar <= 1'b0; m_r <= 1'b0; m_aw <= 1'b0; m_w <= 1'b0;
      m_b <= 1'b0; m_done <= 1'b0;
      m_araddr <= 32'd0; m_awaddr <= 32'd0; m_wdata <= 32'd0; m_rdata <= 32'd0;
      m_wstrb <= 4'd0; m_arsz <= 2'd0; m_awsz <= 2'd0;
    end else begin
      if (!m_busy && req) begin
        m_busy <= 1'b1;
        if (wr) begin
          m_aw <= 1'b1; m_w <= 1'b1;
          m_awaddr <= addr; m_awsz <= size; m_wdata <= wdata; m_wstrb <= wstrb;
        end else begin
          m_ar <= 1'b1; m_araddr <= addr; m_arsz <= size;
        end
      end
      if (m_ar && arready) begin m_ar <= 1'b0; m_r <= 1'b1; end
      if (m_r && rvalid) begin m_r <= 1'b0; m_rdata <= r_data; m_done <= 1'b1; end
      if (m_aw && awready) m_aw <= 1'b0;
      if (m_w && wready) m_w <= 1'b0;
      if ((m_aw || m_w) && !(m_aw && !awready) && !(m_w && !wready)) m_b <= 1'b1;
      if (m_b && bvalid) begin m_b <= 1'b0; m_done <= 1'b1; end
      if (m_done) begin m_done <= 1'b0; m_busy <= 1'b0; end
    end
  end

  // Compare every output against the model on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("addr_ok", {31'd0, addr_ok}, {31'd0, req & ~m_busy});
      chk("data_ok", {31'd0, data_ok}, {31'd0, m_done});
      chk("rdata", rdata, m_rdata);
      chk("arvalid", {31'd0, arvalid}, {31'd0, m_ar});
      chk("araddr", araddr, m_araddr);
      chk("arsize", {29'd0, arsize}, {30'd0, m_arsz});
      chk("rready", {31'd0, rready}, {31'd0, m_r});
      chk("awvalid", {31'd0, awvalid}, {31'd0, m_aw});
      chk("awaddr", awaddr, m_awaddr);
      chk("awsize", {29'd0, awsize}, {30'd0, m_awsz});
      chk("wvalid", {31'd0, wvalid}, {31'd0, m_w});
      chk("w_data", w_data, m_wdata);
      chk("w_strb", {28'd0, w_strb}, {28'd0, m_wstrb});
      chk("bready", {31'd0, bready}, {31'd0, m_b});
      chk("ids", {24'd0, arid, awid}, 32'h0000_0011);
      chk("wlast", {31'd0, wlast}, 32'd1);
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic slave_idle();
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  // Directed scenarios
  initial begin
    int n;
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0;
    wstrb = 4'd0; r_data = 32'd0;
    slave_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
    chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // 1: zero-wait read
    req = 1'b1; wr = 1'b0; addr = 32'h1FAF_F000; size = 2'd2;
    arready = 1'b1; rvalid = 1'b1; r_data = 32'hDEAD_BEEF;
    #1 chk("t1_addr_ok_c0", {31'd0, addr_ok}, 32'd1);
    tick(); req = 1'b0;
    #1 chk("t1_arvalid_c1", {31'd0, arvalid}, 32'd1);
    chk("t1_araddr", araddr, 32'h1FAF_F000);
    chk("t1_arsize", {29'd0, arsize}, 32'd2);
    tick();
    chk("t1_data_ok_c2", {31'd0, data_ok}, 32'd0);
    tick();
    chk("t1_data_ok_c3", {31'd0, data_ok}, 32'd1);
    chk("t1_rdata", rdata, 32'hDEAD_BEEF);
    tick();
    chk("t1_data_ok_c4", {31'd0, data_ok}, 32'd0);
    slave_idle();
    tick();

    // 2: write with AW late, W immediate
    req = 1'b1; wr = 1'b1; addr = 32'h1FD0_F010; wdata = 32'h0000_00A5; wstrb = 4'b0001;
    size = 2'd0; wready = 1'b1;
    tick(); req = 1'b0;
    chk("t2_awvalid_c1", {31'd0, awvalid}, 32'd1);
    chk("t2_wvalid_c1", {31'd0, wvalid}, 32'd1);
    chk("t2_w_data", w_data, 32'h0000_00A5);
    tick();
    chk("t2_wvalid_c2", {31'd0, wvalid}, 32'd0);
    chk("t2_awvalid_c2", {31'd0, awvalid}, 32'd1);
    chk("t2_bready_c2", {31'd0, bready}, 32'd0);
    tick();
    chk("t2_awvalid_c3", {31'd0, awvalid}, 32'd1);
    awready = 1'b1;
    tick(); awready = 1'b0;
    chk("t2_awvalid_c4", {31'd0, awvalid}, 32'd0);
    chk("t2_bready_c4", {31'd0, bready}, 32'd1);
    tick();
    bvalid = 1'b1;
    tick(); bvalid = 1'b0;
    chk("t2_data_ok", {31'd0, data_ok}, 32'd1);
    chk("t2_bready_after", {31'd0, bready}, 32'd0);
    slave_idle();
    tick();

    // 3: AR backpressure with req held high
    req = 1'b1; wr = 1'b0; addr = 32'h1FAF_0040; size = 2'd2;
    #1 chk("t3_addr_ok_c0", {31'd0, addr_ok}, 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_arvalid_hold", {31'd0, arvalid}, 32'd1);
      chk("t3_araddr_hold", araddr, 32'h1FAF_0040);
      chk("t3_addr_ok_busy", {31'd0, addr_ok}, 32'd0);
      tick();
    end
    req = 1'b0; arready = 1'b1; rvalid = 1'b1; r_data = 32'h1234_5678;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n = n + int'(data_ok);
    end
    chk("t3_data_ok_count", n, 32'd1);
    chk("t3_rdata", rdata, 32'h1234_5678);
    slave_idle();
    tick();

    // 4: back-to-back read then write, req continuous
    req = 1'b1; wr = 1'b0; addr = 32'h1FAF_0080; size = 2'd2;
    arready = 1'b1; rvalid = 1'b1; r_data = 32'hCAFE_F00D;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    #1 chk("t4_addr_ok_c0", {31'd0, addr_ok}, 32'd1);
    tick();
    wr = 1'b1; addr = 32'h1FD0_0004; wdata = 32'h1122_3344; wstrb = 4'hF;
    #1 chk("t4_addr_ok_c1", {31'd0, addr_ok}, 32'd0);
    tick();
    chk("t4_addr_ok_c2", {31'd0, addr_ok}, 32'd0);
    tick();
    chk("t4_addr_ok_done", {31'd0, addr_ok}, 32'd0);
    chk("t4_data_ok_c3", {31'd0, data_ok}, 32'd1);
    chk("t4_rdata", rdata, 32'hCAFE_F00D);
    r_data = 32'h0BAD_F00D;
    tick();
    chk("t4_addr_ok_c4", {31'd0, addr_ok}, 32'd1);
    tick(); req = 1'b0;
    chk("t4_awaddr", awaddr, 32'h1FD0_0004);
    chk("t4_wvalid", {31'd0, wvalid}, 32'd1);
    tick();
    chk("t4_bready", {31'd0, bready}, 32'd1);
    tick();
    chk("t4_wr_data_ok", {31'd0, data_ok}, 32'd1);
    chk("t4_rdata_kept", rdata, 32'hCAFE_F00D);
    slave_idle();
    tick();

    // 5: reset while waiting for R
    req = 1'b1; wr = 1'b0; addr = 32'h1FAF_0100; size = 2'd1; arready = 1'b1;
    #1 chk("t5_addr_ok_c0", {31'd0, addr_ok}, 32'd1);
    tick(); req = 1'b0;
    tick();
    #1 chk("t5_rready_c2", {31'd0, rready}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_rready", {31'd0, rready}, 32'd0);
    chk("t5_rst_arsize", {29'd0, arsize}, 32'd0);
    chk("t5_rst_araddr", araddr, 32'd0);
    chk("t5_rst_rdata", rdata, 32'd0);
    chk("t5_rst_data_ok", {31'd0, data_ok}, 32'd0);
    rvalid = 1'b1; r_data = 32'h7777_7777;
    tick();
    rst = 1'b0;
    req = 1'b1; addr = 32'h1FAF_0200; size = 2'd2; r_data = 32'h5A5A_5A5A;
    #1 chk("t5_addr_ok_after_rst", {31'd0, addr_ok}, 32'd1);
    tick(); req = 1'b0;
    chk("t5_no_stale_data_ok", {31'd0, data_ok}, 32'd0);
    tick();
    chk("t5_rready_new", {31'd0, rready}, 32'd1);
    tick();
    chk("t5_data_ok_new", {31'd0, data_ok}, 32'd1);
    chk("t5_rdata_new", rdata, 32'h5A5A_5A5A);
    slave_idle();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
